signed_calc_solver: RTL and testbench

- Sequential inverse of the team's 7a-3b+6c calculator: given an 8-bit target F, finds the first 4-bit unsigned triple (a,b,c) with KA*a - KB*b + KC*c == F (mod 2^W_OUT).
- Runs an FSM-driven exhaustive search, one candidate per clock, with a start/busy/done handshake.
- Used as the equation-solving back end in the combinational-circuits lab datapath and as a self-check partner for the forward calculator.

---
 rtl/signed_calc_pkg.sv | 31 +++
 rtl/calc_eval.sv | 39 +++
 rtl/signed_calc_solver.sv | 132 +++++++++++++
 tb/tb_signed_calc_solver.sv | 247 ++++++++++++++++++++++++
 4 files changed

// File: rtl/signed_calc_pkg.sv
// Shared constants, FSM encoding and index/result types for the 7a-3b+6c inverse solver.
// Latency: none (declarations only).
// Backpressure: none (declarations only).
package signed_calc_pkg;

    localparam int W_IN  = 4;   // width of each solution operand a, b, c
    localparam int W_OUT = 8;   // width of target F; arithmetic is modulo 2^W_OUT
    localparam int KA    = 7;   // coefficient of a (added)
    localparam int KB    = 3;   // coefficient of b (subtracted)
    localparam int KC    = 6;   // coefficient of c (added)

    localparam int W_IDX = 3 * W_IN;

    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        SEARCH = 2'd1,
        DONE   = 2'd2
    } state_e;

    // Candidate index packed as {c, b, a}: a is the fastest-moving field.
    typedef logic [W_IDX-1:0] idx_t;

    localparam idx_t IDX_MAX = '1;

    // Registered search outcome; operands are recovered from the index fields.
    typedef struct packed {
        logic found;
        idx_t index;
    } result_t;

endpackage

// File: rtl/calc_eval.sv
// Combinational evaluator: value = KA*a - KB*b + KC*c (mod 2^W_OUT), match = (value == target).
// Latency: zero cycles, purely combinational.
// Backpressure: none; output follows inputs every cycle.
module calc_eval
    import signed_calc_pkg::*;
(
    input  logic [W_IN-1:0]  a,
    input  logic [W_IN-1:0]  b,
    input  logic [W_IN-1:0]  c,
    input  logic [W_OUT-1:0] target,
    output logic [W_OUT-1:0] value,
    output logic             match
);

    // Two guard bits keep the full signed range (-KB*max .. (KA+KC)*max) exact before truncation.
    localparam int WX = W_OUT + 2;

    localparam logic signed [WX-1:0] KA_X = WX'(KA);
    localparam logic signed [WX-1:0] KB_X = WX'(KB);
    localparam logic signed [WX-1:0] KC_X = WX'(KC);

    logic signed [WX-1:0] ax;
    logic signed [WX-1:0] bx;
    logic signed [WX-1:0] cx;
    logic signed [WX-1:0] sum;

    // Zero-extend the unsigned operands into signed intermediates and form the weighted sum.
    always_comb begin
        ax  = $signed(WX'(a));
        bx  = $signed(WX'(b));
        cx  = $signed(WX'(c));
        sum = KA_X * ax - KB_X * bx + KC_X * cx;
    end

    // Truncation gives the unsigned encoding, so a sum of -1 reads as all ones.
    assign value = W_OUT'(sum);
    assign match = (value == target);

endmodule

// File: rtl/signed_calc_solver.sv
// Exhaustive inverse solver: finds the lowest {c,b,a} with KA*a - KB*b + KC*c == F (mod 2^W_OUT).
// Latency: one candidate per cycle; done pulses index+2 cycles after start, 2^(3*W_IN)+1 if none.
// Backpressure: i_start ignored while busy/done; optional early exit via CALC_SOLVER_ABORT_EN (i_abort).
module signed_calc_solver
    import signed_calc_pkg::*;
(
    input  logic              i_clk,
    input  logic              i_rst,
    input  logic              i_start,
    input  logic [W_OUT-1:0]  i_fu,
`ifdef CALC_SOLVER_ABORT_EN
    input  logic              i_abort,
`endif
    output logic              o_busy,
    output logic              o_done,
    output logic              o_found,
    output logic [W_IN-1:0]   o_au,
    output logic [W_IN-1:0]   o_bu,
    output logic [W_IN-1:0]   o_cu,
    output logic [W_IDX-1:0]  o_index
);

    state_e           state;
    state_e           state_nxt;
    logic [W_OUT-1:0] target;
    idx_t             idx;
    result_t          res;

    logic             accept;
    logic             step;
    logic             hit;
    logic             miss;
    logic             abort;
    logic             eval_match;
    logic [W_OUT-1:0] unused_value;

`ifdef CALC_SOLVER_ABORT_EN
    assign abort = i_abort;
`else
    assign abort = 1'b0;
`endif

    calc_eval u_eval (
        .a      (idx[W_IN-1:0]),
        .b      (idx[2*W_IN-1:W_IN]),
        .c      (idx[3*W_IN-1:2*W_IN]),
        .target (target),
        .value  (unused_value),
        .match  (eval_match)
    );

    // State register; reset drops any search in flight without a done pulse.
    always_ff @(posedge i_clk or posedge i_rst) begin
        if (i_rst) begin
            state <= IDLE;
        end else begin
            state <= state_nxt;
        end
    end

    // Next-state and control decode; abort outranks a match, a match outranks exhaustion.
    always_comb begin
        state_nxt = state;
        accept    = 1'b0;
        step      = 1'b0;
        hit       = 1'b0;
        miss      = 1'b0;
        o_busy    = 1'b0;
        o_done    = 1'b0;
        case (state)
            IDLE: begin
                if (i_start) begin
                    accept    = 1'b1;
                    state_nxt = SEARCH;
                end
            end
            SEARCH: begin
                o_busy = 1'b1;
                if (abort) begin
                    miss      = 1'b1;
                    state_nxt = DONE;
                end else if (eval_match) begin
                    hit       = 1'b1;
                    state_nxt = DONE;
                end else if (idx == IDX_MAX) begin
                    // Terminal check comes before the increment so idx never wraps.
                    miss      = 1'b1;
                    state_nxt = DONE;
                end else begin
                    step = 1'b1;
                end
            end
            DONE: begin
                o_done    = 1'b1;
                state_nxt = IDLE;
            end
            default: begin
                state_nxt = IDLE;
            end
        endcase
    end

    // Target/index/result registers; results are cleared on each accepted start and held otherwise.
    always_ff @(posedge i_clk or posedge i_rst) begin
        if (i_rst) begin
            target <= '0;
            idx    <= '0;
            res    <= '0;
        end else begin
            if (accept) begin
                target <= i_fu;
                idx    <= '0;
                res    <= '0;
            end else if (step) begin
                idx <= idx + 1'b1;
            end
            if (hit) begin
                res.found <= 1'b1;
                res.index <= idx;
            end else if (miss) begin
                res <= '0;
            end
        end
    end

    assign o_found = res.found;
    assign o_index = res.index;
    assign o_au    = res.index[W_IN-1:0];
    assign o_bu    = res.index[2*W_IN-1:W_IN];
    assign o_cu    = res.index[3*W_IN-1:2*W_IN];

endmodule

// File: tb/tb_signed_calc_solver.sv
// Self-checking bench for signed_calc_solver: directed table, hand sequences, random targets vs model.
// Latency: cycle counts measured from the start-accepting edge (edge 0, cycle 1 follows it).
// Backpressure: exercises ignored starts, mid-search reset and (CALC_SOLVER_ABORT_EN) abort.
module tb_signed_calc_solver;
    import signed_calc_pkg::*;

    logic              i_clk = 1'b0;
    logic              i_rst;
    logic              i_start;
    logic [W_OUT-1:0]  i_fu;
`ifdef CALC_SOLVER_ABORT_EN
    logic              i_abort;
`endif
    logic              o_busy;
    logic              o_done;
    logic              o_found;
    logic [W_IN-1:0]   o_au;
    logic [W_IN-1:0]   o_bu;
    logic [W_IN-1:0]   o_cu;
    logic [W_IDX-1:0]  o_index;

    int nchecks = 0;
    int nerrors = 0;

    signed_calc_solver dut (
        .i_clk   (i_clk),
        .i_rst   (i_rst),
        .i_start (i_start),
        .i_fu    (i_fu),
`ifdef CALC_SOLVER_ABORT_EN
        .i_abort (i_abort),
`endif
        .o_busy  (o_busy),
        .o_done  (o_done),
        .o_found (o_found),
        .o_au    (o_au),
        .o_bu    (o_bu),
        .o_cu    (o_cu),
        .o_index (o_index)
    );

    always #5 i_clk = ~i_clk;

    typedef struct {
        int fu;
        int found;
        int a;
        int b;
        int c;
        int index;
        int cyc;
    } vec_t;

    vec_t vecs[7];

    task automatic chk(input string nm, input int act, input int exp);
        nchecks++;
        if (act != exp) begin
            nerrors++;
            $display("FAIL %s: got %0d expected %0d", nm, act, exp);
        end
    endtask

    // Reference: scan c, then b, then a in nested loops; first hit of the equation mod 2^W_OUT wins.
    task automatic model(input int f, output int found, output int a, output int b,
                         output int c, output int index, output int cyc);
        int lim;
        lim   = 1 << W_IN;
        found = 0; a = 0; b = 0; c = 0; index = 0;
        for (int cc = 0; cc < lim && found == 0; cc++)
            for (int bb = 0; bb < lim && found == 0; bb++)
                for (int aa = 0; aa < lim && found == 0; aa++)
                    if (((KA * aa - KB * bb + KC * cc) & ((1 << W_OUT) - 1)) == f) begin
                        found = 1; a = aa; b = bb; c = cc;
                        index = cc * lim * lim + bb * lim + aa;
                    end
        cyc = (found != 0) ? index + 2 : (1 << W_IDX) + 1;
    endtask

    // Present a start for one edge; returns at the falling edge inside cycle 1.
    task automatic start_search(input int fu);
        @(negedge i_clk);
        i_fu    = W_OUT'(fu);
        i_start = 1'b1;
        @(posedge i_clk);
        #1 i_start = 1'b0;
        @(negedge i_clk);
    endtask

    // Advance cycle by cycle until o_done, bounded; busy must be high in every cycle before done.
    task automatic wait_done(input int from, output int cyc, output int busy_ok);
        cyc     = from;
        busy_ok = 1;
        while (!o_done && cyc < 5000) begin
            if (!o_busy) busy_ok = 0;
            @(negedge i_clk);
            cyc++;
        end
        if (o_busy) busy_ok = 0;
    endtask

    task automatic run_vec(input string nm, input vec_t v);
        int cyc;
        int bok;
        start_search(v.fu);
        wait_done(1, cyc, bok);
        chk({nm, "_done_cycle"}, cyc, v.cyc);
        chk({nm, "_found"}, int'(o_found), v.found);
        chk({nm, "_a"}, int'(o_au), v.a);
        chk({nm, "_b"}, int'(o_bu), v.b);
        chk({nm, "_c"}, int'(o_cu), v.c);
        chk({nm, "_index"}, int'(o_index), v.index);
        chk({nm, "_busy"}, bok, 1);
        @(negedge i_clk);
        chk({nm, "_done_one_cycle"}, int'(o_done), 0);
        chk({nm, "_found_hold"}, int'(o_found), v.found);
    endtask

    initial begin
        #2000000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        int cyc;
        int bok;
        int seen;
        vec_t v;

        // fu, found, a, b, c, index, done cycle
        vecs[0] = '{8'h00, 1, 0,  0,  0,    0,    2};
        vecs[1] = '{8'h07, 1, 1,  0,  0,    1,    3};
        vecs[2] = '{8'hFF, 1, 2,  5,  0,   82,   84};
        vecs[3] = '{8'h06, 1, 3,  5,  0,   83,   85};
        vecs[4] = '{8'hD3, 1, 0, 15,  0,  240,  242};
        vecs[5] = '{8'hC3, 1, 15, 0, 15, 3855, 3857};
        vecs[6] = '{8'hC8, 0, 0,  0,  0,    0, 4097};

        i_rst   = 1'b1;
        i_start = 1'b0;
        i_fu    = '0;
`ifdef CALC_SOLVER_ABORT_EN
        i_abort = 1'b0;
`endif
        #22;
        chk("rst_busy", int'(o_busy), 0);
        chk("rst_done", int'(o_done), 0);
        chk("rst_found", int'(o_found), 0);
        chk("rst_index", int'(o_index), 0);
        chk("rst_a", int'(o_au), 0);
        @(negedge i_clk);
        i_rst = 1'b0;

        for (int i = 0; i < 7; i++) run_vec($sformatf("vec%0d", i), vecs[i]);

        // Result holds in IDLE, then the next start clears it, then reset mid-search.
        run_vec("hold", vecs[1]);
        for (int k = 0; k < 4; k++) begin
            @(negedge i_clk);
            chk("hold_found", int'(o_found), 1);
            chk("hold_index", int'(o_index), 1);
        end
        start_search(8'hC8);
        chk("clr_found", int'(o_found), 0);
        chk("clr_a", int'(o_au), 0);
        chk("clr_index", int'(o_index), 0);
        repeat (19) @(negedge i_clk);
        chk("mid_busy", int'(o_busy), 1);
        #2 i_rst = 1'b1;
        #1;
        chk("midrst_busy", int'(o_busy), 0);
        chk("midrst_done", int'(o_done), 0);
        chk("midrst_found", int'(o_found), 0);
        @(negedge i_clk);
        i_rst = 1'b0;
        seen = 0;
        repeat (12) begin
            @(negedge i_clk);
            if (o_done || o_busy) seen = 1;
        end
        chk("midrst_no_done", seen, 0);

        // Reset while a found result is being held.
        run_vec("prerst", vecs[1]);
        #2 i_rst = 1'b1;
        #1;
        chk("idlerst_found", int'(o_found), 0);
        chk("idlerst_a", int'(o_au), 0);
        chk("idlerst_index", int'(o_index), 0);
        @(negedge i_clk);
        i_rst = 1'b0;

        // Restart request and target change during SEARCH are ignored.
        start_search(8'hFF);
        repeat (4) @(negedge i_clk);
        i_start = 1'b1;
        i_fu    = 8'h00;
        repeat (3) @(negedge i_clk);
        i_start = 1'b0;
        i_fu    = 8'h55;
        wait_done(8, cyc, bok);
        chk("ign_done_cycle", cyc, 84);
        chk("ign_found", int'(o_found), 1);
        chk("ign_a", int'(o_au), 2);
        chk("ign_b", int'(o_bu), 5);
        chk("ign_index", int'(o_index), 82);
        chk("ign_busy", bok, 1);
        @(negedge i_clk);

        // Random targets against the reference model.
        for (int r = 0; r < 6; r++) begin
            v.fu = int'($urandom_range(0, 255));
            model(v.fu, v.found, v.a, v.b, v.c, v.index, v.cyc);
            run_vec($sformatf("rnd%0d_f%0d", r, v.fu), v);
        end

`ifdef CALC_SOLVER_ABORT_EN
        // Abort in cycle 10 of an unsolvable search.
        start_search(8'hC8);
        repeat (9) @(negedge i_clk);
        i_abort = 1'b1;
        @(posedge i_clk);
        #1 i_abort = 1'b0;
        @(negedge i_clk);
        chk("abort_done", int'(o_done), 1);
        chk("abort_found", int'(o_found), 0);
        chk("abort_index", int'(o_index), 0);
        @(negedge i_clk);
        // Abort in the same cycle as the F=0x07 match wins over the match.
        start_search(8'h07);
        @(negedge i_clk);
        i_abort = 1'b1;
        @(posedge i_clk);
        #1 i_abort = 1'b0;
        @(negedge i_clk);
        chk("abort_match_done", int'(o_done), 1);
        chk("abort_match_found", int'(o_found), 0);
        chk("abort_match_a", int'(o_au), 0);
        @(negedge i_clk);
`endif

        $display("Simulation finished: %0d checks, %0d errors", nchecks, nerrors);
        $finish;
    end

endmodule
